// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: UART receiver with a configurable frame format.
// The frame format is 5..9 data bits, none/odd/even parity, and 1 or 2 stop bits.
// Reports parity error, framing error and BREAK alongside each received word.
// Optional feature macro UART_RX_MAJORITY_EN: each bit is the 2-of-3 majority
// of the samples at centre-1, centre and centre+1, decided at centre+1.
// When the macro is undefined, each bit is a single sample taken at its centre.
module uart_rx_cfg #(
    parameter int BIT_RATE     = 9600,
    parameter int CLK_HZ       = 50000000,
    parameter int PAYLOAD_BITS = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    uart_rxd,
    input  logic                    uart_rx_en,
    output logic                    uart_rx_valid,
    output logic [PAYLOAD_BITS-1:0] uart_rx_data,
    output logic                    uart_rx_perr,
    output logic                    uart_rx_ferr,
    output logic                    uart_rx_break
);

    localparam int CPB   = CLK_HZ / BIT_RATE;
    localparam int HALF  = CPB / 2;
    localparam int CNT_W = (CPB > 1) ? $clog2(CPB) : 1;

`ifdef UART_RX_MAJORITY_EN
    // Decisions move one cycle later so the sample after the centre is available.
    localparam int SMP_OFS = 1;
`else
    localparam int SMP_OFS = 0;
`endif

    localparam logic [CNT_W-1:0] CNT_START = CNT_W'(HALF - 1 + SMP_OFS);
    localparam logic [CNT_W-1:0] CNT_BIT   = CNT_W'(CPB - 1);
    localparam logic [3:0]       LAST_DATA = 4'(PAYLOAD_BITS - 1);
    localparam logic [3:0]       LAST_STOP = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // Synchroniser
    logic rxd_meta_q, rxd_meta_d;
    logic rxd_s_q, rxd_s_d;

    // FSM and bit timing
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bit_q, bit_d;

    // Frame accumulation
    logic [PAYLOAD_BITS-1:0] sh_q, sh_d;
    logic                    zero_q, zero_d;
    logic                    perr_acc_q, perr_acc_d;
    logic                    ferr_acc_q, ferr_acc_d;
    logic                    brk_wait_q, brk_wait_d;

    // Registered outputs
    logic                    valid_q, valid_d;
    logic [PAYLOAD_BITS-1:0] data_q, data_d;
    logic                    perr_q, perr_d;
    logic                    ferr_q, ferr_d;
    logic                    break_q, break_d;

    // Value of the current bit as decided at its sampling point
    logic bit_val;

`ifdef UART_RX_MAJORITY_EN
    // hist_q[0] is rxd_s one cycle ago (centre), hist_q[1] two cycles ago (centre-1)
    logic [1:0] hist_q, hist_d;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Sample history and majority vote
    always_comb begin
        hist_d  = {hist_q[0], rxd_s_q};
        bit_val = maj3(hist_q[1], hist_q[0], rxd_s_q);
    end

    // History shift register, pure data path
    always_ff @(posedge clk) begin
        hist_q <= hist_d;
    end
`else
    // Single sample at the bit centre
    always_comb begin
        bit_val = rxd_s_q;
    end
`endif

    // Two-flop synchroniser on the asynchronous pad input
    always_comb begin
        rxd_meta_d = uart_rxd;
        rxd_s_d    = rxd_meta_q;
    end

    // Next-state, bit timing, frame accumulation and output capture
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        sh_d       = sh_q;
        zero_d     = zero_q;
        perr_acc_d = perr_acc_q;
        ferr_acc_d = ferr_acc_q;
        brk_wait_d = brk_wait_q;
        valid_d    = 1'b0;
        data_d     = data_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        break_d    = break_q;

        // A BREAK keeps the receiver disarmed until the line returns high
        if (state_q == S_IDLE && rxd_s_q) begin
            brk_wait_d = 1'b0;
        end

        if (!uart_rx_en) begin
            // Abandon any frame in progress; outputs keep their last values
            state_d = S_IDLE;
            cnt_d   = '0;
            bit_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cnt_d = '0;
                    bit_d = '0;
                    if (!rxd_s_q && !brk_wait_q) begin
                        state_d = S_START;
                    end
                end

                S_START: begin
                    if (cnt_q == CNT_START) begin
                        cnt_d = '0;
                        if (bit_val) begin
                            // Line went back high before mid-bit: glitch, not a start
                            state_d = S_IDLE;
                        end else begin
                            state_d    = S_DATA;
                            zero_d     = 1'b1;
                            perr_acc_d = 1'b0;
                            ferr_acc_d = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end

                S_DATA: begin
                    if (cnt_q == CNT_BIT) begin
                        cnt_d = '0;
                        // Shift in at the top so the first bit lands in the LSB
                        sh_d  = {bit_val, sh_q[PAYLOAD_BITS-1:1]};
                        if (bit_val) begin
                            zero_d = 1'b0;
                        end
                        if (bit_q == LAST_DATA) begin
                            bit_d   = '0;
                            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            bit_d = bit_q + 4'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end

                S_PARITY: begin
                    if (cnt_q == CNT_BIT) begin
                        cnt_d = '0;
                        if (bit_val) begin
                            zero_d = 1'b0;
                        end
                        if (PARITY == 1) begin
                            perr_acc_d = (bit_val != ~^sh_q);
                        end else begin
                            perr_acc_d = (bit_val != ^sh_q);
                        end
                        state_d = S_STOP;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end

                S_STOP: begin
                    if (cnt_q == CNT_BIT) begin
                        cnt_d = '0;
                        if (!bit_val) begin
                            ferr_acc_d = 1'b1;
                        end else begin
                            zero_d = 1'b0;
                        end
                        if (bit_q == LAST_STOP) begin
                            // Last stop centre: publish the word and flags
                            bit_d      = '0;
                            state_d    = S_IDLE;
                            valid_d    = 1'b1;
                            data_d     = sh_q;
                            perr_d     = perr_acc_q;
                            ferr_d     = ferr_acc_q | ~bit_val;
                            break_d    = zero_q & ~bit_val;
                            brk_wait_d = zero_q & ~bit_val;
                        end else begin
                            bit_d = bit_q + 4'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end

                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    bit_d   = '0;
                end
            endcase
        end
    end

    // Control, synchroniser and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            rxd_meta_q <= 1'b1;
            rxd_s_q    <= 1'b1;
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            zero_q     <= 1'b0;
            perr_acc_q <= 1'b0;
            ferr_acc_q <= 1'b0;
            brk_wait_q <= 1'b0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            break_q    <= 1'b0;
        end else begin
            rxd_meta_q <= rxd_meta_d;
            rxd_s_q    <= rxd_s_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            zero_q     <= zero_d;
            perr_acc_q <= perr_acc_d;
            ferr_acc_q <= ferr_acc_d;
            brk_wait_q <= brk_wait_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            break_q    <= break_d;
        end
    end

    // Data shift register; fully overwritten by every frame, so no reset
    always_ff @(posedge clk) begin
        sh_q <= sh_d;
    end

    assign uart_rx_valid = valid_q;
    assign uart_rx_data  = data_q;
    assign uart_rx_perr  = perr_q;
    assign uart_rx_ferr  = ferr_q;
    assign uart_rx_break = break_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Testbench for uart_rx_cfg: three receivers (8N1, 8E1, 5O2) sharing one clock.
// A frame model pushes the expected word into a scoreboard; a monitor pops on valid.
module tb_uart_rx_cfg;

    localparam int BIT_RATE = 1000;
    localparam int CLK_HZ   = 16000;
    localparam int CPB      = CLK_HZ / BIT_RATE;
    localparam int HALF     = CPB / 2;

    typedef struct {
        int         d;
        logic [8:0] data;
        logic       perr;
        logic       ferr;
        logic       brk;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic rxd [3];
    logic en  [3];
    logic vld [3];
    logic pe  [3];
    logic fe  [3];
    logic bk  [3];
    logic [8:0] dat [3];
    logic [7:0] d0_data;
    logic [7:0] d1_data;
    logic [4:0] d2_data;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic mon_en   = 1'b0;

    always #5 clk = ~clk;

    uart_rx_cfg #(.BIT_RATE(BIT_RATE), .CLK_HZ(CLK_HZ), .PAYLOAD_BITS(8),
                  .PARITY(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .reset(reset), .uart_rxd(rxd[0]), .uart_rx_en(en[0]),
        .uart_rx_valid(vld[0]), .uart_rx_data(d0_data), .uart_rx_perr(pe[0]),
        .uart_rx_ferr(fe[0]), .uart_rx_break(bk[0]));

    uart_rx_cfg #(.BIT_RATE(BIT_RATE), .CLK_HZ(CLK_HZ), .PAYLOAD_BITS(8),
                  .PARITY(2), .STOP_BITS(1)) dut1 (
        .clk(clk), .reset(reset), .uart_rxd(rxd[1]), .uart_rx_en(en[1]),
        .uart_rx_valid(vld[1]), .uart_rx_data(d1_data), .uart_rx_perr(pe[1]),
        .uart_rx_ferr(fe[1]), .uart_rx_break(bk[1]));

    uart_rx_cfg #(.BIT_RATE(BIT_RATE), .CLK_HZ(CLK_HZ), .PAYLOAD_BITS(5),
                  .PARITY(1), .STOP_BITS(2)) dut2 (
        .clk(clk), .reset(reset), .uart_rxd(rxd[2]), .uart_rx_en(en[2]),
        .uart_rx_valid(vld[2]), .uart_rx_data(d2_data), .uart_rx_perr(pe[2]),
        .uart_rx_ferr(fe[2]), .uart_rx_break(bk[2]));

    assign dat[0] = {1'b0, d0_data};
    assign dat[1] = {1'b0, d1_data};
    assign dat[2] = {4'b0, d2_data};

    function automatic int pb_of(input int d);
        return (d == 2) ? 5 : 8;
    endfunction

    function automatic int par_of(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 2 : 1);
    endfunction

    function automatic int nstop_of(input int d);
        return (d == 2) ? 2 : 1;
    endfunction

    task automatic chk(input string nm, input int act, input int req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every valid pulse must match the oldest expected word
    always @(negedge clk) begin
        if (mon_en) begin
            for (int d = 0; d < 3; d++) begin
                if (vld[d]) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_valid: dut %0d data %0h with empty scoreboard", d, dat[d]);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        chk("valid_dut", d, e.d);
                        chk("data", int'(dat[d]), int'(e.data));
                        chk("perr", int'(pe[d]), int'(e.perr));
                        chk("ferr", int'(fe[d]), int'(e.ferr));
                        chk("break", int'(bk[d]), int'(e.brk));
                    end
                end
            end
        end
    end

    // Build a frame from its fields, predict the received word, then drive it
    // one clock at a time. gl_bit >= 0 puts a one-cycle inverted glitch at the
    // centre of that data bit; abort_bit >= 0 drops enable inside that data bit.
    task automatic send_frame(input int d, input logic [8:0] data, input logic flip,
                              input logic [1:0] stops, input int gl_bit, input int abort_bit);
        logic lv[$];
        logic eff[$];
        exp_t e;
        int   ones;
        int   pb;
        int   gl_idx;
        int   ab_idx;
        logic pbit;
        logic all0;
        pb = pb_of(d);
        lv.push_back(1'b0);
        for (int i = 0; i < pb; i++) lv.push_back(data[i]);
        if (par_of(d) != 0) begin
            ones = $countones(data);
            pbit = (par_of(d) == 1) ? ((ones % 2) == 0) : ((ones % 2) == 1);
            lv.push_back(pbit ^ flip);
        end
        for (int s = 0; s < nstop_of(d); s++) lv.push_back(stops[s]);

        gl_idx = (gl_bit >= 0) ? gl_bit + 1 : -1;
        ab_idx = (abort_bit >= 0) ? abort_bit + 1 : -1;

        // Levels the receiver is expected to decide on
        eff = lv;
`ifndef UART_RX_MAJORITY_EN
        if (gl_idx >= 0) eff[gl_idx] = ~eff[gl_idx];
`endif
        e.d    = d;
        e.data = '0;
        for (int i = 0; i < pb; i++) e.data[i] = eff[i + 1];
        e.perr = 1'b0;
        if (par_of(d) != 0) begin
            ones   = $countones(e.data) + int'(eff[pb + 1]);
            e.perr = (par_of(d) == 1) ? ((ones % 2) == 0) : ((ones % 2) == 1);
        end
        e.ferr = 1'b0;
        for (int s = 0; s < nstop_of(d); s++) begin
            if (eff[eff.size() - 1 - s] == 1'b0) e.ferr = 1'b1;
        end
        all0 = 1'b1;
        for (int i = 1; i < eff.size(); i++) begin
            if (eff[i]) all0 = 1'b0;
        end
        e.brk = all0;
        if (ab_idx < 0) sb.push_back(e);

        for (int b = 0; b < lv.size(); b++) begin
            for (int c = 0; c < CPB; c++) begin
                if (b == ab_idx && c == 5) en[d] = 1'b0;
                rxd[d] = (b == gl_idx && c == HALF) ? ~lv[b] : lv[b];
                tick();
            end
        end
        rxd[d] = 1'b1;
        repeat (CPB) tick();
        if (ab_idx >= 0) begin
            repeat (CPB) tick();
            en[d] = 1'b1;
        end
        chk("sb_drained", sb.size(), 0);
        sb.delete();
    endtask

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] rd;
        logic       fl;
        logic [1:0] st;
        int         mask;

        reset = 1'b1;
        for (int d = 0; d < 3; d++) begin
            rxd[d] = 1'b0;
            en[d]  = 1'b1;
        end

        // Reset held four cycles with the line low
        for (int k = 0; k < 4; k++) begin
            tick();
            for (int d = 0; d < 3; d++) begin
                chk("reset_outputs", int'({vld[d], pe[d], fe[d], bk[d], dat[d]}), 0);
            end
        end
        for (int d = 0; d < 3; d++) rxd[d] = 1'b1;
        tick();
        reset = 1'b0;
        mon_en = 1'b1;
        repeat (3 * CPB) tick();

        // 8N1 0x41
        send_frame(0, 9'h41, 1'b0, 2'b11, -1, -1);
        // 8E1 0x31 with parity bit forced 0 (correct even parity is 1)
        send_frame(1, 9'h31, 1'b1, 2'b11, -1, -1);
        // Stop bit low: framing error only
        send_frame(0, 9'h5A, 1'b0, 2'b00, -1, -1);
        // All-zero frame including stop: BREAK
        send_frame(0, 9'h00, 1'b0, 2'b00, -1, -1);
        send_frame(1, 9'h00, 1'b0, 2'b00, -1, -1);
        send_frame(2, 9'h00, 1'b0, 2'b00, -1, -1);
        // 5O2 with only the second stop bit low
        send_frame(2, 9'h15, 1'b0, 2'b01, -1, -1);

        // Start glitch low for CPB/4 cycles: no frame
        rxd[0] = 1'b0;
        repeat (CPB / 4) tick();
        rxd[0] = 1'b1;
        repeat (3 * CPB) tick();
        chk("false_start", sb.size(), 0);

        // Enable dropped inside data bit 3, then a clean 0xC3
        send_frame(0, 9'hA5, 1'b0, 2'b11, -1, 3);
        send_frame(0, 9'hC3, 1'b0, 2'b11, -1, -1);

        // One-cycle high glitch at the centre of bit 2 of a 0x00 frame
        send_frame(0, 9'h00, 1'b0, 2'b11, 2, -1);

        // Randomized frames on all three formats
        for (int i = 0; i < 8; i++) begin
            for (int d = 0; d < 3; d++) begin
                mask = (1 << pb_of(d)) - 1;
                rd   = 9'($urandom) & 9'(mask);
                fl   = (par_of(d) != 0) && ($urandom_range(0, 3) == 0);
                st   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
                send_frame(d, rd, fl, st, -1, -1);
            end
        end

        repeat (2 * CPB) tick();
        chk("final_drain", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
